// File: rtl/vlc_pkg.sv
// Shared VLC transmit-path definitions: scheduler state encoding and default frame timing.
// The default constants are also used by the encoder bench, so keep them in step with the encoder.
package vlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_STREAM,
    ST_HOLD,
    ST_DRAIN,
    ST_GAP
  } sched_state_t;

  localparam int         VLC_FRAME_BYTES = 24;
  localparam int         VLC_BIT_CYCLES  = 50;
  localparam int         VLC_GAP_CYCLES  = 1000;
  localparam logic [7:0] VLC_FILL_BYTE   = 8'h00;

  function automatic logic is_loading(input sched_state_t st);
    return (st == ST_START) || (st == ST_STREAM);
  endfunction

endpackage

// File: rtl/vlc_rr_arbiter.sv
// Two-way requester arbiter that latches the winner when take is high and anyone is valid.
// VLC_SCHED_RR_EN defined: round-robin pointer; undefined: requester 0 has fixed priority.
module vlc_rr_arbiter (
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] valid,
  input  logic       take,
  output logic       grant
);

  logic winner;
  logic grant_reg;

`ifdef VLC_SCHED_RR_EN
  logic ptr_reg;

  always_comb begin
    winner = ptr_reg;
    if (!valid[ptr_reg]) winner = ~ptr_reg;
  end

  // The pointer moves past whoever just won, so two busy requesters alternate.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= 1'b0;
    end else if (take && (|valid)) begin
      ptr_reg <= ~winner;
    end
  end
`else
  assign winner = ~valid[0];
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      grant_reg <= 1'b0;
    end else if (take && (|valid)) begin
      grant_reg <= winner;
    end
  end

  assign grant = grant_reg;

endmodule

// File: rtl/vlc_tx_scheduler.sv
// Frame scheduler for the 4b6b encoder: arbitrates two byte streams, feeds one byte per encoder
// ready pulse, pads short/stalled frames and enforces the inter-frame gap. Macro: VLC_SCHED_RR_EN.
module vlc_tx_scheduler
  import vlc_pkg::*;
#(
  parameter int         FRAME_BYTES = VLC_FRAME_BYTES,
  parameter int         BIT_CYCLES  = VLC_BIT_CYCLES,
  parameter int         GAP_CYCLES  = VLC_GAP_CYCLES,
  parameter logic [7:0] FILL_BYTE   = VLC_FILL_BYTE
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       enc_encode,
  output logic [7:0] enc_data,
  input  logic       enc_ready,
  input  logic       enc_encoding,
  output logic       grant,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int               CNT_W      = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BYTES);
  localparam logic [15:0]      HOLD_END   = 16'(BIT_CYCLES - 1);
  localparam logic [15:0]      GAP_END    = 16'(GAP_CYCLES - 1);

  sched_state_t     state_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [CNT_W-1:0] byte_cnt_next;
  logic [15:0]      hold_cnt_reg;
  logic [15:0]      gap_cnt_reg;
  logic [7:0]       enc_data_reg;
  logic             encode_reg;
  logic             last_taken_reg;
  logic             frame_done_reg;
  logic             underrun_reg;

  logic [1:0] req_valid;
  logic [1:0] req_last;
  logic [1:0] req_ready;
  logic [7:0] req_data [2];

  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       pop_ok;
  logic       take_byte;
  logic       arb_take;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_last    = {req1_last, req0_last};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  vlc_rr_arbiter u_arbiter (
    .clk   (pclk),
    .srst  (reset),
    .valid (req_valid),
    .take  (arb_take),
    .grant (grant)
  );

  assign arb_take  = (state_reg == ST_ARB);
  assign sel_valid = req_valid[grant];
  assign sel_last  = req_last[grant];
  assign sel_data  = req_data[grant];

  // A pulse may pop a byte only until the granted stream's last byte has gone out.
  assign pop_ok    = enc_ready && is_loading(state_reg) && !last_taken_reg;
  assign take_byte = pop_ok && sel_valid;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = pop_ok && (grant == 1'(gi));
  end

  assign req0_ready    = req_ready[0];
  assign req1_ready    = req_ready[1];
  assign byte_cnt_next = byte_cnt_reg + CNT_W'(1);

  always_ff @(posedge pclk) begin
    frame_done_reg <= 1'b0;
    underrun_reg   <= 1'b0;
    if (reset) begin
      state_reg      <= ST_IDLE;
      byte_cnt_reg   <= '0;
      hold_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      enc_data_reg   <= FILL_BYTE;
      encode_reg     <= 1'b0;
      last_taken_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req_valid) state_reg <= ST_ARB;
        end
        ST_ARB: begin
          if (|req_valid) begin
            state_reg      <= ST_START;
            encode_reg     <= 1'b1;
            byte_cnt_reg   <= '0;
            last_taken_reg <= 1'b0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_START, ST_STREAM: begin
          if (enc_ready) begin
            byte_cnt_reg <= byte_cnt_next;
            if (take_byte) begin
              enc_data_reg <= sel_data;
              if (sel_last) last_taken_reg <= 1'b1;
            end else begin
              enc_data_reg <= FILL_BYTE;
              underrun_reg <= !last_taken_reg;
            end
            if (byte_cnt_next == FRAME_LAST) begin
              state_reg    <= ST_HOLD;
              hold_cnt_reg <= '0;
            end else begin
              state_reg <= ST_STREAM;
            end
          end
        end
        // encode stays up long enough for the encoder's final symbol-boundary check.
        ST_HOLD: begin
          if (hold_cnt_reg == HOLD_END) begin
            encode_reg <= 1'b0;
            state_reg  <= ST_DRAIN;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (!enc_encoding) begin
            frame_done_reg <= 1'b1;
            gap_cnt_reg    <= '0;
            state_reg      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_END) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign enc_encode = encode_reg;
  assign enc_data   = enc_data_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;

endmodule
